mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_pkg.sv | 36 +++
 rtl/mem_load_align.sv | 40 ++++
 rtl/mem_stage.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared definitions for the memory stage: access-size encodings,
//               the stage FSM state type and the alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // Access size encodings; 2'b11 behaves exactly like a word access.
    localparam logic [1:0] c_DSIZE_WORD     = 2'b00;
    localparam logic [1:0] c_DSIZE_HALF     = 2'b01;
    localparam logic [1:0] c_DSIZE_BYTE     = 2'b10;
    localparam logic [1:0] c_DSIZE_WORD_ALT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

    // True when the address offset is illegal for the requested access size.
    function automatic logic is_misaligned(input logic [1:0] dsize, input logic [1:0] addrLow);
        logic result;
        case (dsize)
            c_DSIZE_BYTE:     result = 1'b0;
            c_DSIZE_HALF:     result = addrLow[0];
            c_DSIZE_WORD:     result = (addrLow != 2'b00);
            c_DSIZE_WORD_ALT: result = (addrLow != 2'b00);
            default:          result = (addrLow != 2'b00);
        endcase
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_load_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_load_align
// Description : Selects the addressed byte/halfword lane of a little-endian
//               read word and zero- or sign-extends it to 32 bits.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addrLow,
    input  logic [1:0]  dsize,
    input  logic        loadext,
    output logic [31:0] data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection followed by extension according to access size.
    always_comb begin
        case (addrLow)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
        w_half = addrLow[1] ? rdata[31:16] : rdata[15:0];
        case (dsize)
            c_DSIZE_BYTE:     data = {{24{loadext & w_byte[7]}}, w_byte};
            c_DSIZE_HALF:     data = {{16{loadext & w_half[15]}}, w_half};
            c_DSIZE_WORD:     data = rdata;
            c_DSIZE_WORD_ALT: data = rdata;
            default:          data = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Pipeline memory stage. Registers the exec results, performs
//               one load/store handshake per memory op while stalling the
//               upstream pipeline, and presents results to writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dMemWr,
    input  logic        dMemToReg,
    input  logic        dRegWrite,
    input  logic        dJal,
    input  logic [1:0]  dDsize,
    input  logic        dLoadext,
    input  logic [31:0] dALUout,
    input  logic [31:0] dBusB,
    input  logic [4:0]  dRw,
    input  logic [31:0] dDelayslot2,
    output logic        MemToReg,
    output logic        RegWr,
    output logic        Jal,
    output logic [4:0]  Rw,
    output logic [31:0] ALUout,
    output logic [31:0] MemData,
    output logic [31:0] Delayslot2,
    output logic        misalign,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall
);

    logic        r_memWr;
    logic        r_memToReg;
    logic        r_regWrite;
    logic        r_jal;
    logic [1:0]  r_dsize;
    logic        r_loadext;
    logic [31:0] r_aluOut;
    logic [31:0] r_busB;
    logic [4:0]  r_rw;
    logic [31:0] r_delayslot2;
    logic [31:0] r_memData;
    logic        r_misalign;
    mem_state_t  r_state;

    logic        w_busy;
    logic        w_inMemOp;
    logic        w_inMisaligned;
    logic [31:0] w_loadData;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    assign w_busy         = (r_state == ST_BUSY);
    assign w_inMemOp      = dMemWr | dMemToReg;
    assign w_inMisaligned = is_misaligned(dDsize, dALUout[1:0]);

    // Stage register: every non-stalled edge accepts the next exec result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_memWr      <= 1'b0;
            r_memToReg   <= 1'b0;
            r_regWrite   <= 1'b0;
            r_jal        <= 1'b0;
            r_dsize      <= 2'b00;
            r_loadext    <= 1'b0;
            r_aluOut     <= 32'd0;
            r_busB       <= 32'd0;
            r_rw         <= 5'd0;
            r_delayslot2 <= 32'd0;
        end else if (!w_busy) begin
            r_memWr      <= dMemWr;
            r_memToReg   <= dMemToReg;
            r_regWrite   <= dRegWrite;
            r_jal        <= dJal;
            r_dsize      <= dDsize;
            r_loadext    <= dLoadext;
            r_aluOut     <= dALUout;
            r_busB       <= dBusB;
            r_rw         <= dRw;
            r_delayslot2 <= dDelayslot2;
        end
    end

    // Access FSM with registered load data and misalignment flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_memData  <= 32'd0;
            r_misalign <= 1'b0;
        end else begin
            case (r_state)
                ST_BUSY: begin
                    if (mem_ack) begin
                        r_state <= ST_DONE;
                        if (r_memToReg) begin
                            r_memData <= w_loadData;
                        end
                    end
                end
                default: begin
                    // A new op is captured this edge; misaligned ops never leave IDLE.
                    r_state    <= (w_inMemOp && !w_inMisaligned) ? ST_BUSY : ST_IDLE;
                    r_misalign <= w_inMemOp & w_inMisaligned;
                    r_memData  <= 32'd0;
                end
            endcase
        end
    end

    // Store lane replication and byte enables derived from the held op.
    always_comb begin
        case (r_dsize)
            c_DSIZE_BYTE: begin
                w_be    = 4'b0001 << r_aluOut[1:0];
                w_wdata = {4{r_busB[7:0]}};
            end
            c_DSIZE_HALF: begin
                w_be    = r_aluOut[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{r_busB[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = r_busB;
            end
        endcase
    end

    mem_load_align u_loadAlign (
        .rdata   (mem_rdata),
        .addrLow (r_aluOut[1:0]),
        .dsize   (r_dsize),
        .loadext (r_loadext),
        .data    (w_loadData)
    );

    assign stall      = w_busy;
    assign mem_req    = w_busy;
    assign mem_we     = w_busy & r_memWr;
    assign mem_addr   = {r_aluOut[31:2], 2'b00};
    assign mem_be     = w_be;
    assign mem_wdata  = w_wdata;

    assign MemToReg   = r_memToReg;
    assign RegWr      = r_regWrite & ~w_busy & ~(r_misalign & r_memToReg);
    assign Jal        = r_jal;
    assign Rw         = r_rw;
    assign ALUout     = r_aluOut;
    assign MemData    = r_memData;
    assign Delayslot2 = r_delayslot2;
    assign misalign   = r_misalign;

endmodule
`default_nettype wire
